// File: rtl/cmd_sched_pkg.sv
// Shared types and sizing helpers for the command scheduler issue path.
package cmd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } cmd_issue_state_t;

    localparam int GAP_CYCLES_DFLT = 1;

    function automatic int src_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // A zero-gap build still needs a one-bit counter to stay legal.
    function automatic int gap_cnt_w(input int gap);
        return (gap < 1) ? 1 : $clog2(gap + 1);
    endfunction

    localparam int GAP_CNT_W = gap_cnt_w(GAP_CYCLES_DFLT);

endpackage

// File: rtl/cmd_grant_issuer_onehot_to_bin.sv
// Combinational one-hot encoder with one-hot and zero qualifiers.
module onehot_to_bin
    import cmd_sched_pkg::*;
#(
    parameter int NUM_SRC = 5,
    parameter int IDX_W   = src_idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] vec,
    output logic [IDX_W-1:0]   idx,
    output logic               is_onehot,
    output logic               is_zero
);

    logic [IDX_W:0] ones;

    always_comb begin
        idx  = '0;
        ones = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (vec[i]) begin
                idx  = idx | IDX_W'(i);
                ones = ones + (IDX_W + 1)'(1);
            end
        end
        is_onehot = (ones == (IDX_W + 1)'(1));
        is_zero   = ~|vec;
    end

endmodule

// File: rtl/cmd_grant_issuer.sv
// Turns a validated one-hot grant into a held DRAM command with
// ready/valid issue, a registered source ack and a minimum issue gap.
module cmd_grant_issuer
    import cmd_sched_pkg::*;
#(
    parameter  int NUM_SRC    = 5,
    parameter  int CMD_W      = 32,
    parameter  int GAP_CYCLES = 1,
    localparam int SRC_IDX_W  = src_idx_w(NUM_SRC),
    localparam int GAP_W      = gap_cnt_w(GAP_CYCLES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC-1:0]       grant_onehot,
    input  logic                     look_ahead,
    input  logic [NUM_SRC*CMD_W-1:0] src_cmd,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [CMD_W-1:0]         cmd_data,
    output logic [SRC_IDX_W-1:0]     cmd_src_idx,
    output logic [NUM_SRC-1:0]       src_ack,
    output logic                     busy,
    output logic                     grant_err,
    input  logic                     err_clr
);

    cmd_issue_state_t     state_q, state_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [CMD_W-1:0]     data_q, data_d;
    logic [SRC_IDX_W-1:0] idx_q, idx_d;
    logic [NUM_SRC-1:0]   ack_q, ack_d;
    logic                 err_q, err_d;

    logic [SRC_IDX_W-1:0] enc_idx;
    logic                 enc_onehot;
    logic                 enc_zero;
    logic [CMD_W-1:0]     sel_cmd;
    logic                 err_set;

    onehot_to_bin #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (SRC_IDX_W)
    ) u_enc (
        .vec       (grant_onehot),
        .idx       (enc_idx),
        .is_onehot (enc_onehot),
        .is_zero   (enc_zero)
    );

    always_comb begin
        sel_cmd = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (enc_idx == SRC_IDX_W'(i)) begin
                sel_cmd = src_cmd[i*CMD_W +: CMD_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        data_d    = data_q;
        idx_d     = idx_q;
        ack_d     = '0;
        err_set   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (look_ahead) begin
                    if (enc_onehot) begin
                        data_d  = sel_cmd;
                        idx_d   = enc_idx;
                        state_d = HOLD;
                    end else if (!enc_zero) begin
                        err_set = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (cmd_ready) begin
                    ack_d = NUM_SRC'(1) << idx_q;
                    if (GAP_CYCLES > 0) begin
                        gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
                        state_d   = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // A fresh error outranks a same-cycle clear.
        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
            data_q    <= '0;
            idx_q     <= '0;
            ack_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign cmd_valid   = (state_q == HOLD);
    assign busy        = (state_q != IDLE);
    assign cmd_data    = data_q;
    assign cmd_src_idx = idx_q;
    assign src_ack     = ack_q;
    assign grant_err   = err_q;

endmodule

// File: tb/tb_cmd_grant_issuer.sv
// Directed bench for cmd_grant_issuer at gap settings 1, 0 and 3.
module tb_cmd_grant_issuer;

    localparam int NS = 5;
    localparam int CW = 32;

    typedef struct packed {
        logic [2:0]    idx;
        logic [CW-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NS-1:0]   grant_onehot = '0;
    logic            look_ahead = 1'b0;
    logic [NS*CW-1:0] src_cmd = '0;
    logic            cmd_ready = 1'b0;
    logic            err_clr = 1'b0;

    logic            v1, v0, v3;
    logic [CW-1:0]   d1, d0, d3;
    logic [2:0]      i1, i0, i3;
    logic [NS-1:0]   a1, a0, a3;
    logic            b1, b0, b3;
    logic            e1, e0, e3;

    int   n_cmp = 0;
    int   n_err = 0;
    int   ack_cnt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    cmd_grant_issuer #(.NUM_SRC(NS), .CMD_W(CW), .GAP_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .grant_onehot(grant_onehot),
        .look_ahead(look_ahead), .src_cmd(src_cmd), .cmd_valid(v1),
        .cmd_ready(cmd_ready), .cmd_data(d1), .cmd_src_idx(i1),
        .src_ack(a1), .busy(b1), .grant_err(e1), .err_clr(err_clr)
    );

    cmd_grant_issuer #(.NUM_SRC(NS), .CMD_W(CW), .GAP_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .grant_onehot(grant_onehot),
        .look_ahead(look_ahead), .src_cmd(src_cmd), .cmd_valid(v0),
        .cmd_ready(cmd_ready), .cmd_data(d0), .cmd_src_idx(i0),
        .src_ack(a0), .busy(b0), .grant_err(e0), .err_clr(err_clr)
    );

    cmd_grant_issuer #(.NUM_SRC(NS), .CMD_W(CW), .GAP_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .grant_onehot(grant_onehot),
        .look_ahead(look_ahead), .src_cmd(src_cmd), .cmd_valid(v3),
        .cmd_ready(cmd_ready), .cmd_data(d3), .cmd_src_idx(i3),
        .src_ack(a3), .busy(b3), .grant_err(e3), .err_clr(err_clr)
    );

    always @(posedge clk) begin
        if (|a1) ack_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_idx"}, 64'(i1), 64'(e.idx));
            chk({tag, "_data"}, 64'(d1), 64'(e.data));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        grant_onehot = '0;
        look_ahead = 1'b0;
        cmd_ready = 1'b0;
        err_clr = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int base;
        int hs[$];
        for (int s = 0; s < NS; s++) begin
            src_cmd[s*CW +: CW] = 32'hDEAD_0000 | 32'(s);
        end

        // reset values
        tick();
        tick();
        chk("rst_valid", 64'(v1), 64'd0);
        chk("rst_data", 64'(d1), 64'd0);
        chk("rst_idx", 64'(i1), 64'd0);
        chk("rst_ack", 64'(a1), 64'd0);
        chk("rst_busy", 64'(b1), 64'd0);
        chk("rst_err", 64'(e1), 64'd0);
        rst_n = 1'b1;
        tick();

        // single issue
        grant_onehot = 5'b00100;
        look_ahead = 1'b1;
        cmd_ready = 1'b1;
        sb.push_back('{idx: 3'd2, data: 32'hDEAD_0002});
        tick();
        look_ahead = 1'b0;
        grant_onehot = '0;
        chk("single_valid", 64'(v1), 64'd1);
        sb_check("single");
        tick();
        chk("single_ack", 64'(a1), 64'b00100);
        chk("single_vfall", 64'(v1), 64'd0);
        chk("single_busy_gap", 64'(b1), 64'd1);
        tick();
        chk("single_busy_low", 64'(b1), 64'd0);
        chk("single_ack_gone", 64'(a1), 64'd0);

        // backpressure
        do_reset();
        base = ack_cnt;
        cmd_ready = 1'b0;
        grant_onehot = 5'b01000;
        look_ahead = 1'b1;
        sb.push_back('{idx: 3'd3, data: 32'hDEAD_0003});
        tick();
        grant_onehot = 5'b00001;
        sb_check("bp_first");
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                cmd_ready = 1'b1;
                look_ahead = 1'b0;
            end
            chk("bp_valid", 64'(v1), 64'd1);
            chk("bp_data", 64'(d1), 64'hDEAD_0003);
            chk("bp_idx", 64'(i1), 64'd3);
            chk("bp_ack_quiet", 64'(a1), 64'd0);
            tick();
        end
        chk("bp_ack", 64'(a1), 64'b01000);
        chk("bp_err", 64'(e1), 64'd0);
        grant_onehot = '0;
        tick();
        tick();
        tick();
        chk("bp_ack_count", 64'(ack_cnt - base), 64'd1);

        // multi-hot grant error
        do_reset();
        grant_onehot = 5'b10010;
        look_ahead = 1'b1;
        tick();
        chk("mh_valid", 64'(v1), 64'd0);
        chk("mh_err", 64'(e1), 64'd1);
        chk("mh_busy", 64'(b1), 64'd0);
        grant_onehot = 5'b00011;
        err_clr = 1'b1;
        tick();
        chk("mh_err_wins", 64'(e1), 64'd1);
        chk("mh_valid2", 64'(v1), 64'd0);
        grant_onehot = '0;
        look_ahead = 1'b0;
        tick();
        chk("mh_err_clr", 64'(e1), 64'd0);
        err_clr = 1'b0;

        // async reset mid-HOLD
        do_reset();
        base = ack_cnt;
        cmd_ready = 1'b0;
        grant_onehot = 5'b11000;
        look_ahead = 1'b1;
        tick();
        grant_onehot = 5'b00010;
        tick();
        look_ahead = 1'b0;
        grant_onehot = '0;
        chk("ar_valid_pre", 64'(v1), 64'd1);
        chk("ar_err_pre", 64'(e1), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(v1), 64'd0);
        chk("ar_ack", 64'(a1), 64'd0);
        chk("ar_busy", 64'(b1), 64'd0);
        chk("ar_err", 64'(e1), 64'd0);
        tick();
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("ar_no_ack", 64'(ack_cnt - base), 64'd0);

        // spacing, gap 0 and gap 3
        do_reset();
        grant_onehot = 5'b10000;
        look_ahead = 1'b1;
        cmd_ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k <= 6) begin
                chk("g0_valid", 64'(v0), 64'(k % 2));
                chk("g0_ack", 64'(a0), (k % 2 == 0) ? 64'b10000 : 64'd0);
                if (k % 2 == 1) chk("g0_idx", 64'(i0), 64'd4);
            end
            if (v3 && cmd_ready) hs.push_back(k);
        end
        look_ahead = 1'b0;
        grant_onehot = '0;
        chk("g3_hs_count", 64'(hs.size()), 64'd3);
        if (hs.size() == 3) begin
            chk("g3_hs_first", 64'(hs[0]), 64'd1);
            chk("g3_gap_a", 64'(hs[1] - hs[0]), 64'd5);
            chk("g3_gap_b", 64'(hs[2] - hs[1]), 64'd5);
        end

        // look_ahead gating
        do_reset();
        grant_onehot = 5'b01000;
        look_ahead = 1'b0;
        cmd_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("gate_valid", 64'(v1), 64'd0);
            chk("gate_busy", 64'(b1), 64'd0);
        end

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
